hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Execute-stage sequencer sitting directly upstream of the iterative divider: accepts DIV/DIVU/MTHI/MTLO from EX, latches and holds divider operands, drives the level-sensitive start handshake, stalls the pipeline while a divide is in flight, and commits the 64-bit result into the architectural HI/LO registers. It also owns HI/LO for MFHI/MFLO reads.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_i  in  3  EX operation: 000 NOP, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO, others = NOP
- rs_i  in  32  dividend / MTHI/MTLO source
- rt_i  in  32  divisor
- flush_i  in  1  pipeline flush
- stall_o  out  1  combinational stall request to pipeline control
- div_start_o  out  1  divider start (level; high = start, low = stop)
- div_signed_o  out  1  divider signed select
- div_op1_o  out  32  divider dividend
- div_op2_o  out  32  divider divisor
- div_result_i  in  64  {remainder, quotient}
- div_ready_i  in  1  divider result valid
- hi_o  out  32  current HI
- lo_o  out  32  current LO

## Operation
- States: IDLE, WAIT, ABORT, DRAIN.
- IDLE, op_i DIV/DIVU: latch rs_i→div_op1_o, rt_i→div_op2_o, div_signed_o←(op_i==DIV); div_start_o←1; →WAIT.
- IDLE, op_i MTHI/MTLO: HI (resp. LO) ← rs_i at the edge; no stall; stay IDLE.
- WAIT: operands, signed and start held constant (divider samples them again at its final correction step). When div_ready_i=1: HI←div_result_i[63:32], LO←div_result_i[31:0], div_start_o←0, →DRAIN.
- DRAIN: start low; when div_ready_i=0 →IDLE. Guarantees stale ready is never taken as a new result.
- ABORT: start low, result discarded; when div_ready_i=1 →DRAIN (divider cannot abort mid-iteration; must run to its end state).
- stall_o = (IDLE & op is DIV/DIVU) | (WAIT & ~div_ready_i) | ((DRAIN|ABORT) & op is DIV/DIVU).
- Divide by zero: divider returns 0; HI=LO=0 committed, no exception raised here.
- Operand outputs retain last values outside WAIT.

## Timing
- Reset: state IDLE, div_start_o 0, div_signed_o 0, div_op1_o 0, div_op2_o 0, hi_o 0, lo_o 0. Reset mid-divide returns to IDLE with no HI/LO write; divider shares rst.
- Accept edge → start high next cycle; divider takes 1 edge to enter its on state, 18 edges iterating/correcting, 1 edge to assert ready; capture on the following edge.
- DIV/DIVU occupies EX 22 cycles (stall_o high 21 cycles, low in capture cycle so the instruction advances on the same edge HI/LO update).
- hi_o/lo_o are registered; MFHI in the instruction directly after a DIV sees the new value (capture edge coincides with DIV leaving EX).
- Back-to-back DIV: second is stalled through DRAIN (≥2 extra cycles) before IDLE acceptance.
- MTHI/MTLO and capture never coincide (MT ops only accepted in IDLE).

## Configuration
- DIV_FLUSH_EN defined: flush_i in WAIT → div_start_o←0, →ABORT, no HI/LO write; flush_i in IDLE suppresses acceptance of op_i that cycle (no latch, no MT write).
- Undefined: flush_i ignored in WAIT (divide completes and commits); in IDLE flush_i still suppresses MTHI/MTLO writes and DIV acceptance.

## Test plan
- Reset: hold rst 2 cycles mid-WAIT → all outputs 0, state IDLE, next DIV works.
- DIVU rs=100, rt=7 → stall_o high 21 cycles, then HI=2, LO=14; div_start_o low next cycle.
- DIV rs=-7 (0xFFFFFFF9), rt=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD; div_signed_o=1 throughout WAIT.
- DIV rt=0 → HI=0, LO=0; stall released normally.
- Back-to-back DIVU (100/7 then 9/3) with MFHI between → first HI=2 read correctly; second gives HI=0, LO=3; no stale-ready capture.
- DIV_FLUSH_EN: flush_i at cycle 5 of WAIT with HI=LO=0x11 preloaded via MTHI/MTLO → ABORT/DRAIN, HI/LO stay 0x11; without macro same stimulus commits quotient/remainder.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: execute-stage sequencer for the iterative divider and owner of
// the architectural HI/LO registers.
//   - Accepts DIV/DIVU/MTHI/MTLO from EX.
//   - Holds divider operands and a level-sensitive start for the whole divide.
//   - Stalls the pipeline while a divide is in flight.
//   - Commits {remainder, quotient} into HI/LO.
// Optional feature: define DIV_FLUSH_EN to let flush_i abort an in-flight divide.
// Without it, a divide in flight always completes and commits.
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ABORT,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic   start_d;
  logic   accept;
  logic   commit;
  logic   hi_we;
  logic   lo_we;
  logic   is_div;

  assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, start level, and datapath enables.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    start_d = div_start_o;
    accept  = 1'b0;
    commit  = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A flushed instruction must not start a divide or write HI/LO.
        if (!flush_i) begin
          if (is_div) begin
            accept  = 1'b1;
            start_d = 1'b1;
            state_d = S_WAIT;
          end
          hi_we = (op_i == OP_MTHI);
          lo_we = (op_i == OP_MTLO);
        end
      end
      S_WAIT: begin
`ifdef DIV_FLUSH_EN
        if (flush_i) begin
          // Drop start and discard the result. If ready is already up, go
          // straight to DRAIN so ABORT never waits on a ready that is about
          // to fall.
          start_d = 1'b0;
          state_d = div_ready_i ? S_DRAIN : S_ABORT;
        end else if (div_ready_i) begin
          commit  = 1'b1;
          start_d = 1'b0;
          state_d = S_DRAIN;
        end
`else
        if (div_ready_i) begin
          commit  = 1'b1;
          start_d = 1'b0;
          state_d = S_DRAIN;
        end
`endif
      end
      S_ABORT: begin
        // The divider cannot stop mid-iteration; wait for it to finish.
        start_d = 1'b0;
        if (div_ready_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Wait for ready to fall so a stale ready is never taken as a result.
        start_d = 1'b0;
        if (!div_ready_i) state_d = S_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational stall request; low in the capture cycle so the divide
  // instruction leaves EX on the same edge HI/LO update.
  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      S_IDLE:          stall_o = is_div;
      S_WAIT:          stall_o = ~div_ready_i;
      S_ABORT,
      S_DRAIN:         stall_o = is_div;
      default:         stall_o = 1'b0;
    endcase
  end

  // Divider handshake, held operands, and the architectural HI/LO registers.
  // NOTE: all of these are plain registers, not a memory array, so every one
  // has a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_start_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      div_start_o <= start_d;
      if (accept) begin
        div_op1_o    <= rs_i;
        div_op2_o    <= rt_i;
        div_signed_o <= (op_i == OP_DIV);
      end
      // MT writes happen only in IDLE and capture only in WAIT, so the
      // two write paths below never fire together.
      if (commit) begin
        hi_o <= div_result_i[63:32];
        lo_o <= div_result_i[31:0];
      end
      if (hi_we) hi_o <= rs_i;
      if (lo_we) lo_o <= rs_i;
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl. It includes a behavioural stand-in for the
// iterative divider with this timing:
//   - 1 edge to enter its on state.
//   - 18 edges iterating.
//   - 1 edge to assert ready.
// The stand-in samples the operands at its final step. Expected values are
// hand-computed constants.
`timescale 1ns/1ps
module tb_hilo_div_ctrl;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] DIV  = 3'b001;
  localparam logic [2:0] DIVU = 3'b010;
  localparam logic [2:0] MTHI = 3'b011;
  localparam logic [2:0] MTLO = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        flush_i;
  logic        stall_o, div_start_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  int n_vec = 0;
  int n_err = 0;

  hilo_div_ctrl dut (
    .clk(clk), .rst(rst), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .flush_i(flush_i), .stall_o(stall_o), .div_start_o(div_start_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Divider stand-in: runs to completion once started, even if start drops.
  logic       dv_busy;
  logic [4:0] dv_cnt;
  always @(posedge clk) begin
    if (rst) begin
      dv_busy      <= 1'b0;
      dv_cnt       <= '0;
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
    end else if (dv_busy) begin
      dv_cnt <= dv_cnt + 5'd1;
      if (dv_cnt == 5'd19) begin
        dv_busy     <= 1'b0;
        div_ready_i <= 1'b1;
        if (div_op2_o == 32'd0)
          div_result_i <= '0;
        else if (div_signed_o)
          div_result_i <= {32'($signed(div_op1_o) % $signed(div_op2_o)),
                           32'($signed(div_op1_o) / $signed(div_op2_o))};
        else
          div_result_i <= {div_op1_o % div_op2_o, div_op1_o / div_op2_o};
      end
    end else if (div_ready_i) begin
      if (!div_start_o) div_ready_i <= 1'b0;
    end else if (div_start_o) begin
      dv_busy <= 1'b1;
      dv_cnt  <= 5'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a divide, hold it while stalled, and return just after the edge on
  // which it leaves EX.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic sgn_and, output logic sgn_or,
                         output logic start_drop);
    logic rose;
    logic done;
    op_i = op; rs_i = a; rt_i = b;
    stalls = 0; sgn_and = 1'b1; sgn_or = 1'b0; start_drop = 1'b0;
    rose = 1'b0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (div_start_o) begin
        rose    = 1'b1;
        sgn_and = sgn_and & div_signed_o;
        sgn_or  = sgn_or | div_signed_o;
      end else if (rose) begin
        start_drop = 1'b1;
      end
      if (!stall_o) done = 1'b1;
      else          stalls++;
    end
    if (!done) check("div_timeout_stall", {63'd0, stall_o}, 64'd0);
    tick();
    op_i = NOP;
  endtask

  int   st;
  logic s_and, s_or, s_drop;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_i = NOP; rs_i = '0; rt_i = '0; flush_i = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_start",  {63'd0, div_start_o},  64'd0);
    check("rst_signed", {63'd0, div_signed_o}, 64'd0);
    check("rst_hi",     hi_o, 64'd0);
    check("rst_lo",     lo_o, 64'd0);
    check("rst_stall",  {63'd0, stall_o}, 64'd0);
    tick();
    rst = 1'b0;

    // DIVU 100/7: q=14, r=2.
    run_div(DIVU, 32'd100, 32'd7, st, s_and, s_or, s_drop);
    check("divu1_stalls", st, 64'd21);
    check("divu1_hi", hi_o, 64'd2);
    check("divu1_lo", lo_o, 64'd14);
    check("divu1_start_low", {63'd0, div_start_o}, 64'd0);
    check("divu1_start_held", {63'd0, s_drop}, 64'd0);
    check("divu1_unsigned", {63'd0, s_or}, 64'd0);
    check("op1_retained", div_op1_o, 64'd100);
    // MFHI directly after the divide.
    @(negedge clk);
    check("mfhi_after_div", hi_o, 64'd2);
    tick();
    // Back-to-back DIVU 9/3: stalled through DRAIN first, q=3, r=0.
    run_div(DIVU, 32'd9, 32'd3, st, s_and, s_or, s_drop);
    check("divu2_stalls", st, 64'd22);
    check("divu2_hi", hi_o, 64'd0);
    check("divu2_lo", lo_o, 64'd3);
    repeat (3) tick();

    // MTHI/MTLO preload, no stall.
    op_i = MTHI; rs_i = 32'hAA;
    @(negedge clk);
    check("mthi_no_stall", {63'd0, stall_o}, 64'd0);
    tick();
    op_i = MTLO; rs_i = 32'hAB;
    tick();
    op_i = NOP;
    check("mthi_hi", hi_o, 64'hAA);
    check("mtlo_lo", lo_o, 64'hAB);
    // Flush in IDLE suppresses an MT write.
    op_i = MTHI; rs_i = 32'h55; flush_i = 1'b1;
    tick();
    op_i = NOP; flush_i = 1'b0;
    check("idle_flush_mthi", hi_o, 64'hAA);

    // Reset held 2 cycles mid-WAIT.
    op_i = DIV; rs_i = 32'd100; rt_i = 32'd7;
    tick();
    op_i = NOP;
    repeat (4) tick();
    @(negedge clk);
    check("wait_start_high", {63'd0, div_start_o}, 64'd1);
    check("wait_stall_high", {63'd0, stall_o}, 64'd1);
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("mid_rst_hi",     hi_o, 64'd0);
    check("mid_rst_lo",     lo_o, 64'd0);
    check("mid_rst_op1",    div_op1_o, 64'd0);
    check("mid_rst_op2",    div_op2_o, 64'd0);
    check("mid_rst_start",  {63'd0, div_start_o}, 64'd0);
    check("mid_rst_signed", {63'd0, div_signed_o}, 64'd0);
    check("mid_rst_stall",  {63'd0, stall_o}, 64'd0);
    tick();
    rst = 1'b0;

    // DIV -7/2: q=-3, r=-1.
    run_div(DIV, 32'hFFFF_FFF9, 32'd2, st, s_and, s_or, s_drop);
    check("div_s_stalls", st, 64'd21);
    check("div_s_hi", hi_o, 64'hFFFF_FFFF);
    check("div_s_lo", lo_o, 64'hFFFF_FFFD);
    check("div_s_signed_held", {63'd0, s_and}, 64'd1);
    check("div_s_start_held", {63'd0, s_drop}, 64'd0);
    repeat (3) tick();

    // Divide by zero commits zeros.
    run_div(DIV, 32'd5, 32'd0, st, s_and, s_or, s_drop);
    check("div0_stalls", st, 64'd21);
    check("div0_hi", hi_o, 64'd0);
    check("div0_lo", lo_o, 64'd0);
    repeat (3) tick();

    // Flush at cycle 5 of WAIT with HI=LO=0x11 preloaded.
    op_i = MTHI; rs_i = 32'h11;
    tick();
    op_i = MTLO;
    tick();
    op_i = DIVU; rs_i = 32'd100; rt_i = 32'd7;
    tick();
    repeat (4) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; op_i = NOP;
    repeat (30) tick();
    @(negedge clk);
`ifdef DIV_FLUSH_EN
    check("flush_hi", hi_o, 64'h11);
    check("flush_lo", lo_o, 64'h11);
`else
    check("flush_hi", hi_o, 64'd2);
    check("flush_lo", lo_o, 64'd14);
`endif
    check("flush_start_low", {63'd0, div_start_o}, 64'd0);
    check("flush_stall_low", {63'd0, stall_o}, 64'd0);
    tick();

    // A divide after the flush sequence still works.
    run_div(DIVU, 32'd9, 32'd3, st, s_and, s_or, s_drop);
    check("post_flush_stalls", st, 64'd21);
    check("post_flush_hi", hi_o, 64'd0);
    check("post_flush_lo", lo_o, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
